// File: rtl/spr_dma_if.sv
// Bus bundle between the CPU decode, CPU memory and the PPU register port for the OAM DMA engine.
// master = DMA engine side, slave = surrounding system side.
interface spr_dma_if;
  logic        cpu_ce_in;
  logic [15:0] cpu_a_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_r_nw_in;
  logic [7:0]  mem_d_in;
  logic        cpu_rdy_out;
  logic        dma_active_out;
  logic [15:0] mem_a_out;
  logic [2:0]  ri_sel_out;
  logic        ri_ncs_out;
  logic        ri_r_nw_out;
  logic [7:0]  ri_d_out;

  modport master (
    input  cpu_ce_in, cpu_a_in, cpu_d_in, cpu_r_nw_in, mem_d_in,
    output cpu_rdy_out, dma_active_out, mem_a_out,
    output ri_sel_out, ri_ncs_out, ri_r_nw_out, ri_d_out
  );

  modport slave (
    output cpu_ce_in, cpu_a_in, cpu_d_in, cpu_r_nw_in, mem_d_in,
    input  cpu_rdy_out, dma_active_out, mem_a_out,
    input  ri_sel_out, ri_ncs_out, ri_r_nw_out, ri_d_out
  );
endinterface

// File: rtl/spr_dma.sv
// OAM sprite DMA: on a CPU write to the DMA register, halts the CPU and copies
// 256 bytes of CPU page {page,xx} into the PPU OAM data register.
module spr_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAM_SEL      = 3'h4,
  parameter bit          ALIGN_EN     = 1'b1
) (
  input  logic      clk_in,
  input  logic      rst_in,
  spr_dma_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic        r_parity;
  logic        r_cpu_rdy;
  logic        r_active;
  logic [15:0] r_mem_a;
  logic [2:0]  r_ri_sel;
  logic        r_ri_ncs;
  logic        r_ri_r_nw;
  logic [7:0]  r_ri_d;

  logic w_dma_write;

  assign w_dma_write = !bus.cpu_r_nw_in && (bus.cpu_a_in == DMA_REG_ADDR);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_parity  <= 1'b0;
      r_cpu_rdy <= 1'b1;
      r_active  <= 1'b0;
      r_mem_a   <= 16'h0000;
      r_ri_sel  <= 3'h0;
      r_ri_ncs  <= 1'b1;
      r_ri_r_nw <= 1'b1;
      r_ri_d    <= 8'h00;
    end else begin
      // Strobe falls back every clk so it stays one clk wide even with ce tied high.
      r_ri_ncs  <= 1'b1;
      r_ri_r_nw <= 1'b1;
      if (bus.cpu_ce_in) begin
        r_parity <= ~r_parity;
        case (r_state)
          S_IDLE: begin
            if (w_dma_write) begin
              r_page    <= bus.cpu_d_in;
              r_idx     <= 8'h00;
              r_state   <= S_HALT;
              r_cpu_rdy <= 1'b0;
              r_active  <= 1'b1;
            end
          end
          S_HALT: begin
            if (ALIGN_EN && r_parity) begin
              r_state <= S_ALIGN;
            end else begin
              r_state <= S_READ;
              r_mem_a <= {r_page, r_idx};
            end
          end
          S_ALIGN: begin
            r_state <= S_READ;
            r_mem_a <= {r_page, r_idx};
          end
          S_READ: begin
            // ri_d doubles as the read buffer: captured as the read cycle ends.
            r_state   <= S_WRITE;
            r_ri_ncs  <= 1'b0;
            r_ri_r_nw <= 1'b0;
            r_ri_sel  <= OAM_SEL;
            r_ri_d    <= bus.mem_d_in;
          end
          S_WRITE: begin
            r_idx <= r_idx + 8'd1;
            if (r_idx == 8'hFF) begin
              r_state   <= S_IDLE;
              r_cpu_rdy <= 1'b1;
              r_active  <= 1'b0;
            end else begin
              r_state <= S_READ;
              r_mem_a <= {r_page, r_idx + 8'd1};
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cpu_rdy_out    = r_cpu_rdy;
  assign bus.dma_active_out = r_active;
  assign bus.mem_a_out      = r_mem_a;
  assign bus.ri_sel_out     = r_ri_sel;
  assign bus.ri_ncs_out     = r_ri_ncs;
  assign bus.ri_r_nw_out    = r_ri_r_nw;
  assign bus.ri_d_out       = r_ri_d;

endmodule
